clkdiv_multi: RTL and testbench
===============================

# clkdiv_multi

Multi-channel, runtime-programmable clock divider and tick generator. Each of CH channels divides `clk` by its own divisor D and produces a one-cycle tick per period plus a mode-selectable output: pulse or near-50 % square. Divisor and mode reloads are glitch-free: they take effect only at a period boundary or on a global `sync`. The block sits next to the peripheral timing logic and feeds UART baud ticks, PWM bases and LED/scan strobes.

## Interface
- `CH`, default 4: number of channels, ≥ 1.
- `DIV_W`, default 16: divisor width; D ranges from 1 to 2^DIV_W − 1.
- `DEF_DIV`, default 4: divisor loaded at reset into every channel, 1 ≤ DEF_DIV < 2^DIV_W.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global count enable; when low, every counter holds.
- `sync`  in  1  single-cycle restart of all channels.
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_ch`  in  CH_W = max(1, clog2(CH))  target channel.
- `cfg_div`  in  DIV_W  new divisor. A value of 0 is stored as 1.
- `cfg_mode`  in  1  0 = pulse, 1 = square.
- `pend`  out  CH  per channel: 1 while a written configuration is waiting to be applied.
- `tick`  out  CH  one-cycle pulse per period.
- `out`  out  CH  mode-dependent divided output.

## Operation
Per-channel state:
- `cnt` (DIV_W bits).
- Active `cur_div` / `cur_mode`.
- Shadow `sh_div` / `sh_mode`.
- `pend`.

Reset values:
- `cnt` = 0.
- `cur_div` = `sh_div` = DEF_DIV.
- `cur_mode` = `sh_mode` = 0.
- `pend`, `tick`, `out` = 0.

Configuration write:
- When `cfg_wr` = 1 and `cfg_ch` < CH: `sh_*[cfg_ch]` ← (cfg_div ? cfg_div : 1, cfg_mode), and `pend[cfg_ch]` ← 1.
- When `cfg_ch` ≥ CH the write is ignored.
- A write to a channel that is already pending overwrites the shadow; the last write wins.

Counting (per edge, with D = `cur_div`):
- **Wrap**: when `en` = 1 and `cnt` = D − 1, `cnt` ← 0.
  - If `pend` is set: `cur_*` ← `sh_*` and `pend` ← 0.
- **Increment**: when `en` = 1 and it is not a wrap edge, `cnt` ← `cnt` + 1.
- **Hold**: when `en` = 0, `cnt` and `cur_*` hold.
- When D = 1, every enabled edge is a wrap edge.

Sync:
- `sync` = 1 forces, on every channel, `cnt` ← 0.
- If `pend` is set, the same edge performs `cur_*` ← `sh_*` and `pend` ← 0.
- `sync` has priority over `en` and over the wrap/increment rules.

Outputs (all registered):
- `tick[k]` = 1 in the cycle after a wrap edge, and 0 otherwise. `sync` is not a wrap and produces no tick.
- Pulse mode: `out[k]` = `tick[k]`.
- Square mode: `out[k]` = (`cnt` < H), where H = (D + 1) >> 1 is computed in DIV_W+1 bits. The value is evaluated against the current-cycle `cnt`/`cur_div` and registered from next-state values, so `out` is glitch-free.
  - Odd D gives high for (D + 1)/2 cycles and low for (D − 1)/2.
  - D = 1 gives `out` constant 1.
- With `en` = 0: `tick` = 0, and a square-mode `out` holds its level.

## Timing
- A tick occurs every D enabled cycles. The first tick after reset, with `en` held high, appears in cycle DEF_DIV, counting the first enabled edge as cycle 1.
- `pend` rises in the cycle after `cfg_wr`. It falls in the cycle after the applying wrap or sync edge.
- A new D or mode governs the period that starts at `cnt` = 0 after the applying edge. A period in progress is never truncated or stretched.
- Simultaneous events:
  - A `cfg_wr` on the same edge as that channel's wrap: the new value goes to the shadow and stays pending until the next boundary. The old shadow, if pending, is applied at this edge.
  - A `cfg_wr` together with `sync`: the same rule applies; `sync` applies the pre-edge shadow.
- Asserting `rst_n` mid-period immediately clears all state to the reset values. Pending configurations are lost.
- `en` deasserted mid-period: the period resumes from the held `cnt`, and no phase is lost.

## Test plan
- **Default divisor**: reset release, `en` = 1, DEF_DIV = 4 → `tick[0..3]` pulses in cycles 4, 8, 12, …, exactly 1 cycle wide; `out` = `tick`.
- **Square mode, odd D**: write ch1 with D = 5, mode 1 → `pend[1]` = 1 until the next ch1 wrap. Afterwards `out[1]` follows the pattern 1,1,1,0,0 repeating, and `tick[1]` occurs every 5 cycles. Other channels are unchanged.
- **Boundary-aligned reload**: ch2 running D = 4 (`cnt` = 1); write D = 10 → the current period finishes at 4 cycles, the next tick interval is 10, and there is no runt pulse.
- **Last write wins, and collision**:
  - Two writes to ch0 (D = 7, then D = 3) before the wrap → D = 3 is applied.
  - A write landing on the wrap edge → stays pending for one more period.
- **Sync and enable**:
  - `en` low for 6 cycles mid-period → ticks are delayed by exactly 6 cycles.
  - `sync` → all `cnt` = 0, pending configurations are applied, no tick is produced, and all channels tick aligned D cycles later.
- **Edge cases**:
  - A write of D = 0 → treated as 1: `tick` high every enabled cycle, square `out` constant 1.
  - `cfg_ch` = CH (with CH = 3) → ignored.
  - `rst_n` pulse mid-period → all outputs 0, `pend` cleared.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / tick generator with shadowed,
// boundary-aligned divisor and mode reloads.
module clkdiv_multi #(
  parameter int CH      = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 4,
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sync,
  input  logic            cfg_wr,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic            cfg_mode,
  output logic [CH-1:0]   pend,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   out
);

  logic [DIV_W-1:0] cnt_q     [CH];
  logic [DIV_W-1:0] cur_div_q [CH];
  logic [DIV_W-1:0] sh_div_q  [CH];
  logic [CH-1:0]    cur_mode_q;
  logic [CH-1:0]    sh_mode_q;

  logic [DIV_W-1:0] cnt_d     [CH];
  logic [DIV_W-1:0] cur_div_d [CH];
  logic [DIV_W-1:0] sh_div_d  [CH];
  logic [DIV_W:0]   half      [CH];
  logic [CH-1:0]    cur_mode_d;
  logic [CH-1:0]    sh_mode_d;
  logic [CH-1:0]    pend_d;
  logic [CH-1:0]    tick_d;
  logic [CH-1:0]    out_d;
  logic [CH-1:0]    last;
  logic [CH-1:0]    wrap;
  logic [CH-1:0]    bnd;
  logic [CH-1:0]    hit;
  logic [DIV_W-1:0] wr_div;

  assign wr_div = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      cnt_d[k]      = cnt_q[k];
      cur_div_d[k]  = cur_div_q[k];
      sh_div_d[k]   = sh_div_q[k];
      cur_mode_d[k] = cur_mode_q[k];
      sh_mode_d[k]  = sh_mode_q[k];
      pend_d[k]     = pend[k];
      half[k]       = '0;

      // Channel indices >= CH never match, so those writes fall away.
      hit[k]  = cfg_wr && (cfg_ch == CH_W'(k));
      last[k] = (cnt_q[k] == cur_div_q[k] - DIV_W'(1));
      wrap[k] = en && !sync && last[k];
      bnd[k]  = sync || wrap[k];

      if (sync || wrap[k])
        cnt_d[k] = '0;
      else if (en)
        cnt_d[k] = cnt_q[k] + DIV_W'(1);

      // The applying edge uses the pre-edge shadow; a same-edge write stays pending.
      if (bnd[k] && pend[k]) begin
        cur_div_d[k]  = sh_div_q[k];
        cur_mode_d[k] = sh_mode_q[k];
        pend_d[k]     = 1'b0;
      end
      if (hit[k]) begin
        sh_div_d[k]  = wr_div;
        sh_mode_d[k] = cfg_mode;
        pend_d[k]    = 1'b1;
      end

      half[k]   = ({1'b0, cur_div_d[k]} + (DIV_W+1)'(1)) >> 1;
      tick_d[k] = wrap[k];
      out_d[k]  = cur_mode_d[k] ? ({1'b0, cnt_d[k]} < half[k]) : wrap[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        cnt_q[k]     <= '0;
        cur_div_q[k] <= DIV_W'(DEF_DIV);
        sh_div_q[k]  <= DIV_W'(DEF_DIV);
      end
      cur_mode_q <= '0;
      sh_mode_q  <= '0;
      pend       <= '0;
      tick       <= '0;
      out        <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        cnt_q[k]     <= cnt_d[k];
        cur_div_q[k] <= cur_div_d[k];
        sh_div_q[k]  <= sh_div_d[k];
      end
      cur_mode_q <= cur_mode_d;
      sh_mode_q  <= sh_mode_d;
      pend       <= pend_d;
      tick       <= tick_d;
      out        <= out_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: directed literal checks plus randomized traffic
// checked every cycle against a period/phase model of each channel.
module tb_clkdiv_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  pend, tick, out;
  logic [2:0]  pend3, tick3, out3;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  bit chk_on = 0;

  // Behavioural model: phase within period, active and shadow configuration.
  int m_pos[4], m_div[4], m_sdiv[4];
  bit m_mode[4], m_smode[4], m_pend[4], m_tick[4];

  always #5 clk = ~clk;

  clkdiv_multi #(.CH(4), .DIV_W(16), .DEF_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .pend(pend), .tick(tick), .out(out)
  );

  // Three-channel instance: cfg_ch = 3 is out of range for it.
  clkdiv_multi #(.CH(3), .DIV_W(16), .DEF_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .pend(pend3), .tick(tick3), .out(out3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc_n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_tick();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_tick[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_pend();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_pend[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_out();
    logic [3:0] v;
    for (int k = 0; k < 4; k++)
      v[k] = m_mode[k] ? (m_pos[k] < (m_div[k] + 1) / 2) : m_tick[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pos[k] = 0; m_div[k] = 4; m_sdiv[k] = 4;
      m_mode[k] = 0; m_smode[k] = 0; m_pend[k] = 0; m_tick[k] = 0;
    end
  endtask

  task automatic model_edge(input bit e, input bit s, input bit w, input int c,
                            input int d, input bit m);
    for (int k = 0; k < 4; k++) begin
      bit ends_period;
      ends_period = ((m_pos[k] + 1) % m_div[k]) == 0;
      m_tick[k] = !s && e && ends_period;
      if (s) m_pos[k] = 0;
      else if (e) m_pos[k] = (m_pos[k] + 1) % m_div[k];
      if ((s || m_tick[k]) && m_pend[k]) begin
        m_div[k] = m_sdiv[k]; m_mode[k] = m_smode[k]; m_pend[k] = 0;
      end
      if (w && c == k) begin
        m_sdiv[k] = (d == 0) ? 1 : d; m_smode[k] = m; m_pend[k] = 1;
      end
    end
  endtask

  task automatic step(input bit e, input bit s, input bit w, input int c,
                      input int d, input bit m);
    en = e; sync = s; cfg_wr = w; cfg_ch = 2'(c); cfg_div = 16'(d); cfg_mode = m;
    @(posedge clk);
    model_edge(e, s, w, c, d, m);
    cyc_n++;
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_pend", int'(pend), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    en = 0; sync = 0; cfg_wr = 0;
    rst_n = 1'b1;
    cyc_n = 0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tick", int'(tick), int'(exp_tick()));
      chk("out", int'(out), int'(exp_out()));
      chk("pend", int'(pend), int'(exp_pend()));
      chk("tick3", int'(tick3), int'(exp_tick() & 4'h7));
      chk("out3", int'(out3), int'(exp_out() & 4'h7));
      if (!(cfg_wr && cfg_ch == 2'd3))
        chk("pend3", int'(pend3), int'(exp_pend() & 4'h7));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] am[4];
    model_reset();
    do_reset();
    chk_on = 1;

    // Default divisor, boundary-aligned reload, last-write-wins, write on wrap.
    for (int k = 0; k < 4; k++) am[k] = '0;
    for (int n = 1; n <= 25; n++) begin
      case (n)
        2: step(1, 0, 1, 2, 10, 0);
        5: step(1, 0, 1, 0, 7, 0);
        6: step(1, 0, 1, 0, 3, 0);
        8: step(1, 0, 1, 1, 5, 1);
        default: idle();
      endcase
      for (int k = 0; k < 4; k++) am[k] |= 32'(tick[k]) << n;
      if (n == 2)  chk("pend2_set", int'(pend[2]), 1);
      if (n == 4)  chk("pend2_clr", int'(pend[2]), 0);
      if (n == 4)  chk("out_eq_tick_c4", int'(out), 4'hf);
      if (n == 11) chk("pend1_held", int'(pend[1]), 1);
      if (n == 12) chk("pend1_clr", int'(pend[1]), 0);
      if (n >= 12 && n <= 17)
        chk("sq_out1", int'(out[1]), (n == 15 || n == 16) ? 0 : 1);
    end
    chk("ticks_ch0", int'(am[0]), (1<<4)|(1<<8)|(1<<11)|(1<<14)|(1<<17)|(1<<20)|(1<<23));
    chk("ticks_ch1", int'(am[1]), (1<<4)|(1<<8)|(1<<12)|(1<<17)|(1<<22));
    chk("ticks_ch2", int'(am[2]), (1<<4)|(1<<14)|(1<<24));
    chk("ticks_ch3", int'(am[3]), (1<<4)|(1<<8)|(1<<12)|(1<<16)|(1<<20)|(1<<24));

    // Enable hold, sync on a would-be wrap, D = 0, out-of-range channel.
    do_reset();
    for (int n = 1; n <= 21; n++) begin
      if (n >= 3 && n <= 8) step(0, 0, 0, 0, 0, 0);
      else if (n == 12) step(1, 0, 1, 3, 0, 1);
      else if (n == 13) step(1, 0, 1, 1, 6, 0);
      else if (n == 14) step(1, 1, 0, 0, 0, 0);
      else idle();
      if (n == 4)  chk("en_hold_no_tick", int'(tick[0]), 0);
      if (n == 10) chk("en_delayed_tick", int'(tick), 4'hf);
      if (n == 12) chk("pend3_ignored", int'(pend3), 0);
      if (n == 13) chk("pend_both", int'(pend), 4'b1010);
      if (n == 13) chk("pend3_ch1", int'(pend3), 3'b010);
      if (n == 14) chk("sync_no_tick", int'(tick), 0);
      if (n == 14) chk("sync_pend_clr", int'(pend), 0);
      if (n >= 14) chk("d1_out_high", int'(out[3]), 1);
      if (n >= 15) chk("d1_tick", int'(tick[3]), 1);
      if (n == 18) chk("sync_aligned", int'(tick), 4'b1101);
      if (n == 20) chk("ch1_d6_tick", int'(tick[1]), 1);
    end
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      bit e, s, w, m;
      int c, d;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 59) == 0);
      w = ($urandom_range(0, 6) == 0);
      c = $urandom_range(0, 3);
      d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      m = 1'($urandom_range(0, 1));
      step(e, s, w, c, d, m);
    end

    @(negedge clk);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
